// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Feeds decimal digits of the multiplier product to the seven-segment driver.
module bin2bcd_seq #(
  parameter int N      = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [N-1:0]          bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy,
  output logic                  done,
  output logic                  valid
);

  localparam int BW = 4 * DIGITS;
  localparam int W  = BW + N;
  localparam int CW = $clog2(N + 1);

  localparam longint unsigned MaxBin = (64'd1 << N) - 64'd1;
  localparam longint unsigned MaxDec = 64'(10) ** DIGITS;

  if (MaxDec <= MaxBin) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for N");
  end

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   scr_q, scr_d;
  logic [N-1:0]    bin_q, bin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;

  logic [BW-1:0]   adj;
  logic [W-1:0]    wr_sh;

  // Add-3 on every nibble >= 5 before the shift; max result 12 fits 4 bits.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  assign wr_sh = {adj, bin_q} << 1;

  always_comb begin
    state_d = state_q;
    scr_d   = scr_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(N);
          state_d = CONV;
        end
      end
      CONV: begin
        scr_d = wr_sh[W-1:N];
        bin_d = wr_sh[N-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = wr_sh[W-1:N];
          done_d  = 1'b1;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      scr_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scr_q   <= scr_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign bcd_out = bcd_q;
  assign busy    = (state_q == CONV);
  assign done    = done_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus a random sweep
// compared against a decimal-arithmetic reference.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [11:0] bin_in;
  logic [15:0] bcd_out;
  logic        busy;
  logic        done;
  logic        valid;

  int ntests = 0;
  int nfail  = 0;
  int ndone  = 0;
  int nacc   = 0;
  logic [15:0] last_bcd;

  bin2bcd_seq #(.N(12), .DIGITS(4)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .done    (done),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) ndone++;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start a conversion now, walk it to the done cycle checking every edge.
  task automatic run_conv(input int v);
    logic [15:0] exp;
    exp = to_bcd(v);
    start  = 1'b1;
    bin_in = 12'(v);
    tick();
    nacc++;
    start = 1'b0;
    for (int i = 1; i < 12; i++) begin
      chk("busy_mid", {15'd0, busy}, 16'd1);
      chk("done_mid", {15'd0, done}, 16'd0);
      chk("hold_mid", bcd_out, last_bcd);
      tick();
    end
    chk("busy_mid", {15'd0, busy}, 16'd1);
    tick();
    chk("done_pulse", {15'd0, done}, 16'd1);
    chk("busy_end", {15'd0, busy}, 16'd0);
    chk("valid_end", {15'd0, valid}, 16'd1);
    chk("bcd_result", bcd_out, exp);
    last_bcd = exp;
  endtask

  initial begin
    int v;
    clr    = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    last_bcd = '0;
    #2;
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_valid", {15'd0, valid}, 16'd0);
    start = 1'b1;
    tick();
    chk("clr_blocks_start", {15'd0, busy}, 16'd0);
    start = 1'b0;
    clr   = 1'b0;
    tick();

    run_conv(0);
    chk("bcd_zero", bcd_out, 16'h0000);
    tick();
    chk("done_one_cycle", {15'd0, done}, 16'd0);
    run_conv(3969);
    chk("bcd_3969", bcd_out, 16'h3969);
    tick();
    run_conv(4095);
    chk("bcd_4095", bcd_out, 16'h4095);
    tick();
    run_conv(10);
    tick();
    run_conv(9);
    chk("bcd_9", bcd_out, 16'h0009);
    tick();

    // Second start while busy is ignored.
    start  = 1'b1;
    bin_in = 12'd1234;
    tick();
    nacc++;
    start = 1'b0;
    repeat (4) tick();
    start  = 1'b1;
    bin_in = 12'd777;
    tick();
    start = 1'b0;
    for (int i = 6; i < 12; i++) begin
      chk("ign_done", {15'd0, done}, 16'd0);
      tick();
    end
    tick();
    chk("ign_done_pulse", {15'd0, done}, 16'd1);
    chk("ign_result", bcd_out, 16'h1234);
    last_bcd = 16'h1234;
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("ign_no_extra", {15'd0, done | busy}, 16'd0);
    end

    // Start during the done cycle: next done exactly 13 edges later.
    run_conv(3969);
    run_conv(250);
    chk("b2b_result", bcd_out, 16'h0250);
    tick();

    // Asynchronous abort mid-conversion.
    run_conv(42);
    tick();
    start  = 1'b1;
    bin_in = 12'd4000;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #3;
    clr = 1'b1;
    #1;
    chk("abort_bcd", bcd_out, 16'h0000);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_valid", {15'd0, valid}, 16'd0);
    tick();
    clr = 1'b0;
    last_bcd = '0;
    for (int i = 0; i < 14; i++) begin
      chk("abort_no_done", {15'd0, done | busy}, 16'd0);
      tick();
    end
    run_conv(4000);
    chk("abort_restart", bcd_out, 16'h4000);
    tick();

    // Start held high: one completion every 13 edges.
    start  = 1'b1;
    bin_in = 12'd321;
    tick();
    nacc++;
    for (int c = 0; c < 3; c++) begin
      v = int'($urandom_range(0, 4095));
      repeat (11) tick();
      bin_in = 12'(v);
      tick();
      chk("held_done", {15'd0, done}, 16'd1);
      chk("held_result", bcd_out, c == 0 ? to_bcd(321) : last_bcd);
      last_bcd = bcd_out;
      tick();
      nacc++;
      last_bcd = to_bcd(v);
    end
    start = 1'b0;
    repeat (12) tick();
    chk("held_last", bcd_out, last_bcd);
    tick();

    // Random sweep, including both range ends.
    run_conv(4095);
    tick();
    for (int n = 0; n < 60; n++) begin
      v = int'($urandom_range(0, 4095));
      run_conv(v);
      if ($urandom_range(0, 1) == 1) tick();
    end
    tick();
    chk("done_count", 16'(ndone), 16'(nacc));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
